// File: rtl/prbs_frame_checker_if.sv
// Word stream in, framing status and error statistics out, between the
// test-control logic (master) and the PRBS frame checker (slave).
interface prbs_frame_checker_if #(
    parameter int CNT_WIDTH = 32
);
    logic [9:0]           data_in;
    logic                 clear_cnt;
    logic                 locked;
    logic                 frame_ok;
    logic                 frame_bad;
    logic [15:0]          frame_bit_errs;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0] frame_err_cnt;
    logic [CNT_WIDTH-1:0] bit_err_cnt;

    modport master (
        output data_in, clear_cnt,
        input  locked, frame_ok, frame_bad, frame_bit_errs,
               frame_cnt, frame_err_cnt, bit_err_cnt
    );

    modport slave (
        input  data_in, clear_cnt,
        output locked, frame_ok, frame_bad, frame_bit_errs,
               frame_cnt, frame_err_cnt, bit_err_cnt
    );
endinterface

// File: rtl/prbs_frame_checker.sv
// Comma-framed PRBS receive checker: acquires alignment on the comma word,
// checks frame structure and payload bits against the LFSR recurrence.
module prbs_frame_checker #(
    parameter int         PRBS_LENGTH = 8,
    parameter int         INV_PATTERN = 1,
    parameter int         POLY_LENGTH = 9,
    parameter int         POLY_TAP    = 5,
    parameter logic [9:0] COMMA       = 10'b1100110011,
    parameter int         CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs_frame_checker_if.slave  bus
);
    localparam int WCNT_W = (PRBS_LENGTH > 1) ? $clog2(PRBS_LENGTH) : 1;

    typedef enum logic [2:0] {
        ST_HUNT      = 3'd0,
        ST_CAND      = 3'd1,
        ST_WAIT_HEAD = 3'd2,
        ST_PAYLOAD   = 3'd3,
        ST_TAIL      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [POLY_LENGTH-1:0] hist_q, hist_d;
    logic [15:0]            acc_q, acc_d;
    logic [WCNT_W-1:0]      cnt_q, cnt_d;
    logic                   locked_q, locked_d;
    logic                   ok_q, ok_d;
    logic                   bad_q, bad_d;
    logic [15:0]            fbe_q, fbe_d;
    logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0]   ferr_q, ferr_d;
    logic [CNT_WIDTH-1:0]   berr_q, berr_d;

    logic                   comma_s;
    logic                   last_word_s;
    logic [POLY_LENGTH-1:0] hist_w_s;
    logic [WCNT_W-1:0]      base_s;
    logic [3:0]             errs_s;
    logic                   rx_bit_s;
    logic                   exp_bit_s;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [15:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH+1)'(b);
        sat_add = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    assign comma_s     = (bus.data_in == COMMA);
    assign last_word_s = (cnt_q == WCNT_W'(PRBS_LENGTH - 1));

    // Serial unroll of the 10 bits of the current word against the recurrence.
    // Outside PAYLOAD the word can only be payload word 0, so history starts empty.
    always_comb begin
        hist_w_s  = (state_q == ST_PAYLOAD) ? hist_q : {POLY_LENGTH{1'b0}};
        base_s    = (state_q == ST_PAYLOAD) ? cnt_q : {WCNT_W{1'b0}};
        errs_s    = 4'd0;
        rx_bit_s  = 1'b0;
        exp_bit_s = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rx_bit_s  = bus.data_in[9-j];
            exp_bit_s = hist_w_s[POLY_LENGTH-1] ^ hist_w_s[POLY_TAP-1] ^ INV_PATTERN[0];
            if ((10 * int'(base_s) + j >= POLY_LENGTH) && (rx_bit_s != exp_bit_s)) begin
                errs_s = errs_s + 4'd1;
            end else begin
                errs_s = errs_s;
            end
            hist_w_s = {hist_w_s[POLY_LENGTH-2:0], rx_bit_s};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:      state_d = comma_s ? ST_CAND : ST_HUNT;
            ST_CAND: begin
                if (comma_s) begin
                    state_d = ST_CAND;
                end else begin
                    state_d = (PRBS_LENGTH == 1) ? ST_TAIL : ST_PAYLOAD;
                end
            end
            ST_WAIT_HEAD: begin
                if (comma_s) begin
                    state_d = ST_PAYLOAD;
                end else if (bus.data_in == 10'h000) begin
                    state_d = ST_WAIT_HEAD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_PAYLOAD:   state_d = last_word_s ? ST_TAIL : ST_PAYLOAD;
            ST_TAIL:      state_d = comma_s ? ST_WAIT_HEAD : ST_HUNT;
            default:      state_d = ST_HUNT;
        endcase
    end

    // Datapath and output next values; clear_cnt overrides any counter update.
    always_comb begin
        hist_d   = hist_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        ok_d     = 1'b0;
        bad_d    = 1'b0;
        fbe_d    = fbe_q;
        fcnt_d   = fcnt_q;
        ferr_d   = ferr_q;
        berr_d   = berr_q;
        case (state_q)
            ST_CAND: begin
                if (!comma_s) begin
                    hist_d = hist_w_s;
                    acc_d  = {12'd0, errs_s};
                    cnt_d  = WCNT_W'(1);
                end else begin
                    hist_d = {POLY_LENGTH{1'b0}};
                    acc_d  = 16'd0;
                end
            end
            ST_WAIT_HEAD: begin
                if (comma_s) begin
                    hist_d = {POLY_LENGTH{1'b0}};
                    acc_d  = 16'd0;
                    cnt_d  = {WCNT_W{1'b0}};
                end else if (bus.data_in != 10'h000) begin
                    bad_d    = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    bad_d = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                hist_d = hist_w_s;
                acc_d  = acc_q + {12'd0, errs_s};
                cnt_d  = cnt_q + WCNT_W'(1);
            end
            ST_TAIL: begin
                if (comma_s) begin
                    ok_d     = 1'b1;
                    fbe_d    = acc_q;
                    fcnt_d   = sat_add(fcnt_q, 16'd1);
                    berr_d   = sat_add(berr_q, acc_q);
                    locked_d = 1'b1;
                end else begin
                    bad_d    = 1'b1;
                    locked_d = 1'b0;
                end
                acc_d = 16'd0;
            end
            default: begin
                hist_d = {POLY_LENGTH{1'b0}};
                acc_d  = 16'd0;
            end
        endcase
        // Violations only count against an established lock.
        if (bad_d && locked_q) begin
            ferr_d = sat_add(ferr_q, 16'd1);
        end else begin
            ferr_d = ferr_d;
        end
        if (bus.clear_cnt) begin
            fbe_d  = 16'd0;
            fcnt_d = {CNT_WIDTH{1'b0}};
            ferr_d = {CNT_WIDTH{1'b0}};
            berr_d = {CNT_WIDTH{1'b0}};
        end else begin
            fbe_d = fbe_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q   <= {POLY_LENGTH{1'b0}};
            acc_q    <= 16'd0;
            cnt_q    <= {WCNT_W{1'b0}};
            locked_q <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            fbe_q    <= 16'd0;
            fcnt_q   <= {CNT_WIDTH{1'b0}};
            ferr_q   <= {CNT_WIDTH{1'b0}};
            berr_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            hist_q   <= hist_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            fbe_q    <= fbe_d;
            fcnt_q   <= fcnt_d;
            ferr_q   <= ferr_d;
            berr_q   <= berr_d;
        end
    end

    assign bus.locked         = locked_q;
    assign bus.frame_ok       = ok_q;
    assign bus.frame_bad      = bad_q;
    assign bus.frame_bit_errs = fbe_q;
    assign bus.frame_cnt      = fcnt_q;
    assign bus.frame_err_cnt  = ferr_q;
    assign bus.bit_err_cnt    = berr_q;
endmodule

// File: tb/tb_prbs_frame_checker.sv
// Bench for prbs_frame_checker: random PRBS frames from a generator model,
// expected payload errors from the recurrence applied to the flattened bit array.
module tb_prbs_frame_checker;
    localparam int         PL    = 8;
    localparam int         INV   = 1;
    localparam int         PLEN  = 9;
    localparam int         PTAP  = 5;
    localparam logic [9:0] COMMA = 10'b1100110011;
    localparam int         NB    = 10 * PL;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_ok;
    int   n_bad;
    int   exp_fcnt;
    int   exp_ferr;
    int   exp_berr;
    logic [9:0] pay [PL];

    prbs_frame_checker_if #(.CNT_WIDTH(32)) bus ();

    prbs_frame_checker #(
        .PRBS_LENGTH(PL), .INV_PATTERN(INV), .POLY_LENGTH(PLEN),
        .POLY_TAP(PTAP), .COMMA(COMMA), .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic gen_frame();
        int b [NB];
        for (int k = 0; k < NB; k++) begin
            if (k < PLEN) b[k] = int'($urandom_range(0, 1));
            else          b[k] = b[k-PLEN] ^ b[k-PTAP] ^ INV;
        end
        for (int w = 0; w < PL; w++)
            for (int j = 0; j < 10; j++)
                pay[w][9-j] = b[10*w+j][0];
    endtask

    function automatic int model_errs();
        int b [NB];
        int e = 0;
        for (int w = 0; w < PL; w++)
            for (int j = 0; j < 10; j++)
                b[10*w+j] = int'(pay[w][9-j]);
        for (int k = PLEN; k < NB; k++)
            if (b[k] != (b[k-PLEN] ^ b[k-PTAP] ^ INV)) e++;
        return e;
    endfunction

    task automatic send(input logic [9:0] w);
        @(negedge clk);
        bus.data_in = w;
        @(posedge clk);
        #1;
        if (bus.frame_ok)  n_ok++;
        if (bus.frame_bad) n_bad++;
    endtask

    task automatic send_body();
        send(COMMA);
        for (int i = 0; i < PL; i++) send(pay[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.data_in = 10'h000;
        bus.clear_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.locked, bus.frame_ok, bus.frame_bad} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.locked, bus.frame_ok, bus.frame_bad});
        end
        checks++;
        if ({bus.frame_cnt, bus.frame_err_cnt, bus.bit_err_cnt, bus.frame_bit_errs} !== 112'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0", bus.frame_cnt,
                     bus.frame_err_cnt, bus.bit_err_cnt, bus.frame_bit_errs);
        end
        @(negedge clk);
        rst = 1'b0;
        n_ok = 0; n_bad = 0;
        repeat (20) send(10'h000);
        checks++;
        if (n_ok != 0 || n_bad != 0 || bus.locked !== 1'b0 || bus.frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL idle_zeros: got ok=%0d bad=%0d locked=%b cnt=%0d expected 0/0/0/0",
                     n_ok, n_bad, bus.locked, bus.frame_cnt);
        end
    endtask

    task automatic test_clean_frames();
        n_ok = 0;
        for (int f = 0; f < 3; f++) begin
            gen_frame();
            send_body();
            send(COMMA);
            exp_fcnt++;
            checks++;
            if (bus.frame_ok !== 1'b1 || bus.locked !== 1'b1 || bus.frame_bit_errs !== 16'd0) begin
                errors++;
                $display("FAIL clean_tail%0d: got ok=%b locked=%b errs=%0d expected 1/1/0",
                         f, bus.frame_ok, bus.locked, bus.frame_bit_errs);
            end
            if (f == 1) repeat ($urandom_range(1, 3)) send(10'h000);
        end
        checks++;
        if (n_ok != 3 || bus.frame_cnt !== 32'(exp_fcnt) || bus.bit_err_cnt !== 32'd0 ||
            bus.frame_err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL clean_totals: got pulses=%0d cnt=%0d berr=%0d ferr=%0d expected 3/%0d/0/0",
                     n_ok, bus.frame_cnt, bus.bit_err_cnt, bus.frame_err_cnt, exp_fcnt);
        end
    endtask

    task automatic test_bit_errors();
        int e;
        gen_frame();
        pay[5][4] = ~pay[5][4];
        e = model_errs();
        send_body();
        send(COMMA);
        exp_fcnt++;
        exp_berr += e;
        checks++;
        if (bus.frame_ok !== 1'b1 || bus.frame_bit_errs !== 16'd3 || bus.bit_err_cnt !== 32'(exp_berr)) begin
            errors++;
            $display("FAIL flip_k55: got ok=%b errs=%0d total=%0d expected 1/3/%0d",
                     bus.frame_ok, bus.frame_bit_errs, bus.bit_err_cnt, exp_berr);
        end
        for (int r = 0; r < 6; r++) begin
            gen_frame();
            repeat ($urandom_range(0, 3)) begin
                int w, bt;
                w  = int'($urandom_range(0, PL - 1));
                bt = int'($urandom_range(0, 9));
                pay[w][bt] = ~pay[w][bt];
            end
            e = model_errs();
            send_body();
            send(COMMA);
            exp_fcnt++;
            exp_berr += e;
            checks++;
            if (bus.frame_ok !== 1'b1 || bus.frame_bit_errs !== 16'(e) ||
                bus.bit_err_cnt !== 32'(exp_berr) || bus.frame_cnt !== 32'(exp_fcnt)) begin
                errors++;
                $display("FAIL rand_flip%0d: got ok=%b errs=%0d total=%0d cnt=%0d expected 1/%0d/%0d/%0d",
                         r, bus.frame_ok, bus.frame_bit_errs, bus.bit_err_cnt, bus.frame_cnt,
                         e, exp_berr, exp_fcnt);
            end
        end
    endtask

    task automatic test_bad_tail();
        gen_frame();
        send_body();
        send(10'h000);
        exp_ferr++;
        checks++;
        if (bus.frame_bad !== 1'b1 || bus.locked !== 1'b0 || bus.frame_err_cnt !== 32'(exp_ferr) ||
            bus.frame_cnt !== 32'(exp_fcnt)) begin
            errors++;
            $display("FAIL bad_tail: got bad=%b locked=%b ferr=%0d cnt=%0d expected 1/0/%0d/%0d",
                     bus.frame_bad, bus.locked, bus.frame_err_cnt, bus.frame_cnt, exp_ferr, exp_fcnt);
        end
        gen_frame();
        send_body();
        send(10'h3FF);
        checks++;
        if (bus.frame_bad !== 1'b1 || bus.frame_err_cnt !== 32'(exp_ferr)) begin
            errors++;
            $display("FAIL bad_unlocked: got bad=%b ferr=%0d expected 1/%0d",
                     bus.frame_bad, bus.frame_err_cnt, exp_ferr);
        end
        n_ok = 0;
        for (int f = 0; f < 2; f++) begin
            gen_frame();
            send_body();
            send(COMMA);
            exp_fcnt++;
        end
        checks++;
        if (n_ok != 2 || bus.locked !== 1'b1 || bus.frame_cnt !== 32'(exp_fcnt)) begin
            errors++;
            $display("FAIL relock: got pulses=%0d locked=%b cnt=%0d expected 2/1/%0d",
                     n_ok, bus.locked, bus.frame_cnt, exp_fcnt);
        end
    endtask

    task automatic test_wait_head_garbage();
        send(10'h155);
        exp_ferr++;
        checks++;
        if (bus.frame_bad !== 1'b1 || bus.locked !== 1'b0 || bus.frame_err_cnt !== 32'(exp_ferr)) begin
            errors++;
            $display("FAIL wait_head_garbage: got bad=%b locked=%b ferr=%0d expected 1/0/%0d",
                     bus.frame_bad, bus.locked, bus.frame_err_cnt, exp_ferr);
        end
        gen_frame();
        pay[2][7] = ~pay[2][7];
        send(COMMA);
        send_body();
        send(COMMA);
        exp_fcnt++;
        exp_berr += model_errs();
        checks++;
        if (bus.frame_ok !== 1'b1 || bus.locked !== 1'b1 || bus.frame_bit_errs !== 16'(model_errs()) ||
            bus.bit_err_cnt !== 32'(exp_berr)) begin
            errors++;
            $display("FAIL comma_pair_align: got ok=%b locked=%b errs=%0d total=%0d expected 1/1/%0d/%0d",
                     bus.frame_ok, bus.locked, bus.frame_bit_errs, bus.bit_err_cnt, model_errs(), exp_berr);
        end
    endtask

    task automatic test_clear();
        gen_frame();
        pay[0][0] = ~pay[0][0];
        send_body();
        bus.clear_cnt = 1'b1;
        send(COMMA);
        bus.clear_cnt = 1'b0;
        exp_fcnt = 0; exp_ferr = 0; exp_berr = 0;
        checks++;
        if (bus.frame_ok !== 1'b1 || bus.locked !== 1'b1 ||
            {bus.frame_cnt, bus.frame_err_cnt, bus.bit_err_cnt, bus.frame_bit_errs} !== 112'd0) begin
            errors++;
            $display("FAIL clear_with_ok: got ok=%b locked=%b cnt=%0d ferr=%0d berr=%0d errs=%0d expected 1/1/0/0/0/0",
                     bus.frame_ok, bus.locked, bus.frame_cnt, bus.frame_err_cnt, bus.bit_err_cnt,
                     bus.frame_bit_errs);
        end
        gen_frame();
        send_body();
        send(COMMA);
        exp_fcnt++;
        checks++;
        if (bus.frame_cnt !== 32'(exp_fcnt) || bus.bit_err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL count_after_clear: got cnt=%0d berr=%0d expected %0d/0",
                     bus.frame_cnt, bus.bit_err_cnt, exp_fcnt);
        end
    endtask

    task automatic test_rst_mid_frame();
        gen_frame();
        send(COMMA);
        for (int i = 0; i < 4; i++) send(pay[i]);
        @(negedge clk);
        rst = 1'b1;
        bus.data_in = pay[4];
        @(posedge clk);
        #1;
        exp_fcnt = 0; exp_ferr = 0; exp_berr = 0;
        checks++;
        if ({bus.locked, bus.frame_ok, bus.frame_bad} !== 3'b000 ||
            {bus.frame_cnt, bus.frame_err_cnt, bus.bit_err_cnt, bus.frame_bit_errs} !== 112'd0) begin
            errors++;
            $display("FAIL rst_mid_frame: got locked=%b ok=%b bad=%b cnt=%0d berr=%0d expected all 0",
                     bus.locked, bus.frame_ok, bus.frame_bad, bus.frame_cnt, bus.bit_err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        gen_frame();
        send_body();
        send(COMMA);
        exp_fcnt++;
        checks++;
        if (bus.frame_ok !== 1'b1 || bus.frame_cnt !== 32'(exp_fcnt) || bus.frame_bit_errs !== 16'd0) begin
            errors++;
            $display("FAIL after_rst_frame: got ok=%b cnt=%0d errs=%0d expected 1/%0d/0",
                     bus.frame_ok, bus.frame_cnt, bus.frame_bit_errs, exp_fcnt);
        end
    endtask

    initial begin
        checks = 0; errors = 0; n_ok = 0; n_bad = 0;
        exp_fcnt = 0; exp_ferr = 0; exp_berr = 0;
        test_reset();
        test_clean_frames();
        test_bit_errors();
        test_bad_tail();
        test_wait_head_garbage();
        test_clear();
        test_rst_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
